// File: rtl/qtable_update_sched_if.sv
// Bus bundle between the Q-table update scheduler and its neighbours
// (packet source, update engine, auxiliary memory requester).
interface qtable_update_sched_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    // Packet header input
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [WORD_WIDTH-1:0] pkt_sourceID;
    logic [WORD_WIDTH-1:0] pkt_hops;
    logic [WORD_WIDTH-1:0] pkt_clusterID;
    logic [WORD_WIDTH-1:0] pkt_energy;
    logic [WORD_WIDTH-1:0] pkt_qvalue;
    logic [WORD_WIDTH-1:0] pkt_knownCH;
    logic [2:0]            pkt_type;

    // Engine operands and control
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fClusterID;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fKnownCH;
    logic [2:0]            fPacketType;
    logic                  upd_en;
    logic                  upd_done;

    // Memory bank sharing and status
    logic                  aux_req;
    logic                  aux_grant;
    logic                  mem_sel;
    logic                  busy;
    logic                  timeout_err;
    logic [7:0]            drop_count;
    logic [15:0]           done_count;

    // Environment side: drives headers, engine completion and aux requests
    modport master (
        output pkt_valid, pkt_sourceID, pkt_hops, pkt_clusterID, pkt_energy,
               pkt_qvalue, pkt_knownCH, pkt_type, upd_done, aux_req,
        input  pkt_ready, fSourceID, fSourceHops, fClusterID, fEnergyLeft,
               fQValue, fKnownCH, fPacketType, upd_en, aux_grant, mem_sel,
               busy, timeout_err, drop_count, done_count
    );

    // Scheduler side
    modport slave (
        input  pkt_valid, pkt_sourceID, pkt_hops, pkt_clusterID, pkt_energy,
               pkt_qvalue, pkt_knownCH, pkt_type, upd_done, aux_req,
        output pkt_ready, fSourceID, fSourceHops, fClusterID, fEnergyLeft,
               fQValue, fKnownCH, fPacketType, upd_en, aux_grant, mem_sel,
               busy, timeout_err, drop_count, done_count
    );
endinterface

// File: rtl/qtable_update_sched.sv
// Q-table update scheduler: header FIFO with type filter, one-at-a-time
// engine launch with completion timeout, and round-robin sharing of the
// neighbour/CH memory banks with an auxiliary requester.
module qtable_update_sched #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    qtable_update_sched_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [2:0]            ptype;
        logic [WORD_WIDTH-1:0] src_id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] cluster_id;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] qvalue;
        logic [WORD_WIDTH-1:0] known_ch;
    } hdr_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_AUX    = 2'd3
    } state_e;

    state_e             state_q;
    hdr_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               rr_last_q;
    logic [TMO_W-1:0]   wait_cnt_q;

    logic               pkt_ready_q;
    hdr_t               f_q;
    logic               upd_en_q;
    logic               aux_grant_q;
    logic               busy_q;
    logic               timeout_err_q;
    logic [7:0]         drop_cnt_q;
    logic [15:0]        done_cnt_q;

    hdr_t               hdr_in_c;
    logic               type_ok_c;
    logic               push_c;
    logic               drop_c;
    logic               launch_c;
    logic               aux_c;

    // Header capture, filtering, slot arbitration and FIFO occupancy
    always_comb begin
        hdr_in_c            = '0;
        hdr_in_c.ptype      = bus.pkt_type;
        hdr_in_c.src_id     = bus.pkt_sourceID;
        hdr_in_c.hops       = bus.pkt_hops;
        hdr_in_c.cluster_id = bus.pkt_clusterID;
        hdr_in_c.energy     = bus.pkt_energy;
        hdr_in_c.qvalue     = bus.pkt_qvalue;
        hdr_in_c.known_ch   = bus.pkt_knownCH;

        type_ok_c = (bus.pkt_type != 3'b000) && (bus.pkt_type != 3'b111);
        push_c    = bus.pkt_valid && pkt_ready_q && type_ok_c;
        drop_c    = bus.pkt_valid && pkt_ready_q && !type_ok_c;

        // rr_last_q = 1 means aux was served last, so the engine wins a tie
        launch_c  = (state_q == S_IDLE) && (count_q != '0) && (!bus.aux_req || rr_last_q);
        aux_c     = (state_q == S_IDLE) && bus.aux_req && !launch_c;

        count_d = count_q;
        if (push_c && !launch_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (launch_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= hdr_in_c;
        end
    end

    // FIFO pointers, ready flag and drop counter
    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_ready_q <= 1'b1;
            drop_cnt_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (launch_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            pkt_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
            if (drop_c && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // Slot sequencer: launch/wait for the engine or lend the banks to aux
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q       <= S_IDLE;
            rr_last_q     <= 1'b0;
            wait_cnt_q    <= '0;
            f_q           <= '0;
            upd_en_q      <= 1'b0;
            aux_grant_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            done_cnt_q    <= '0;
        end else begin
            upd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch_c) begin
                        state_q   <= S_LAUNCH;
                        f_q       <= mem_q[rd_ptr_q];
                        rr_last_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else if (aux_c) begin
                        state_q     <= S_AUX;
                        rr_last_q   <= 1'b1;
                        aux_grant_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state_q    <= S_WAIT;
                    upd_en_q   <= 1'b1;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (bus.upd_done) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        done_cnt_q <= done_cnt_q + 16'd1;
                    end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TMO_W'(1);
                    end
                end
                S_AUX: begin
                    if (!bus.aux_req) begin
                        state_q     <= S_IDLE;
                        aux_grant_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pkt_ready   = pkt_ready_q;
    assign bus.fPacketType = f_q.ptype;
    assign bus.fSourceID   = f_q.src_id;
    assign bus.fSourceHops = f_q.hops;
    assign bus.fClusterID  = f_q.cluster_id;
    assign bus.fEnergyLeft = f_q.energy;
    assign bus.fQValue     = f_q.qvalue;
    assign bus.fKnownCH    = f_q.known_ch;
    assign bus.upd_en      = upd_en_q;
    assign bus.aux_grant   = aux_grant_q;
    assign bus.mem_sel     = aux_grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.done_count  = done_cnt_q;
endmodule

// File: tb/tb_qtable_update_sched.sv
// Randomized bench for qtable_update_sched: every cycle the DUT outputs are
// compared against a queue-based reference model, plus directed scenarios.
module tb_qtable_update_sched;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_WAIT   = 2;
    localparam int P_AUX    = 3;

    typedef struct packed {
        logic [2:0]   ptype;
        logic [W-1:0] src;
        logic [W-1:0] hops;
        logic [W-1:0] clus;
        logic [W-1:0] energy;
        logic [W-1:0] qv;
        logic [W-1:0] ch;
    } hdr_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    qtable_update_sched_if #(.WORD_WIDTH(W)) bus ();

    qtable_update_sched #(
        .WORD_WIDTH(W),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    hdr_t        mq[$];
    int          m_phase;
    int          m_waited;
    bit          m_aux_last;
    hdr_t        m_f;
    bit          m_upd;
    bit          m_terr;
    int          m_drops;
    logic [15:0] m_dones;

    // Environment behaviour knobs
    bit aux_cur;
    int aux_hold;
    int aux_mode;   // 0 never, 1 random, 2 re-request immediately
    int eng_mode;   // 0 random (may never finish), 1 done after 5, 2 never, 3 fast
    int done_at;
    bit spur_en;

    // Observed activity
    logic [W-1:0] launched[$];
    bit           slot_seq[$];   // 1 = aux grant started, 0 = engine launch
    bit           prev_grant;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] obs_vec();
        return 160'({bus.pkt_ready, bus.upd_en, bus.aux_grant, bus.mem_sel, bus.busy,
                     bus.timeout_err, bus.drop_count, bus.done_count, bus.fPacketType,
                     bus.fSourceID, bus.fSourceHops, bus.fClusterID, bus.fEnergyLeft,
                     bus.fQValue, bus.fKnownCH});
    endfunction

    function automatic logic [159:0] exp_vec();
        bit g   = (m_phase == P_AUX);
        bit rdy = (mq.size() < DEPTH);
        bit bsy = (m_phase != P_IDLE);
        return 160'({rdy, m_upd, g, g, bsy, m_terr, 8'(m_drops), m_dones, m_f});
    endfunction

    function automatic hdr_t rand_hdr(input logic [W-1:0] id, input bit allow_bad);
        hdr_t h;
        h.src    = id;
        h.hops   = W'($urandom);
        h.clus   = W'($urandom);
        h.energy = W'($urandom);
        h.qv     = W'($urandom);
        h.ch     = W'($urandom);
        if (allow_bad && ($urandom_range(0, 7) == 0)) begin
            h.ptype = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
        end else begin
            h.ptype = 3'($urandom_range(1, 6));
        end
        return h;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase    = P_IDLE;
        m_waited   = 0;
        m_aux_last = 1'b0;
        m_f        = '0;
        m_upd      = 1'b0;
        m_terr     = 1'b0;
        m_drops    = 0;
        m_dones    = '0;
        aux_cur    = 1'b0;
        done_at    = -1;
        prev_grant = 1'b0;
    endtask

    // Advance the model across one clock edge given the inputs of that cycle
    task automatic model_tick(input bit v, input hdr_t h, input bit done, input bit aux);
        bit room = (mq.size() < DEPTH);
        bit good = (h.ptype != 3'b000) && (h.ptype != 3'b111);
        bit work = (mq.size() != 0);
        m_upd = (m_phase == P_LAUNCH);
        case (m_phase)
            P_IDLE: begin
                if (work && (!aux || m_aux_last)) begin
                    m_f        = mq.pop_front();
                    m_aux_last = 1'b0;
                    m_phase    = P_LAUNCH;
                end else if (aux) begin
                    m_aux_last = 1'b1;
                    m_phase    = P_AUX;
                end
            end
            P_LAUNCH: begin
                m_phase  = P_WAIT;
                m_waited = 0;
            end
            P_WAIT: begin
                if (done) begin
                    m_dones++;
                    m_phase = P_IDLE;
                end else if (m_waited == TMO - 1) begin
                    m_terr  = 1'b1;
                    m_phase = P_IDLE;
                end else begin
                    m_waited++;
                end
            end
            default: begin
                if (!aux) m_phase = P_IDLE;
            end
        endcase
        if (v && room) begin
            if (good) mq.push_back(h);
            else if (m_drops < 255) m_drops++;
        end
    endtask

    // One clock cycle: compare, choose engine/aux responses, drive, advance
    task automatic step(input bit v, input hdr_t h, input bit rst, output bit acc);
        bit done;
        check("cyc", obs_vec(), exp_vec());
        if (bus.upd_en === 1'b1) begin
            launched.push_back(bus.fSourceID);
            slot_seq.push_back(1'b0);
        end
        if ((bus.aux_grant === 1'b1) && !prev_grant) slot_seq.push_back(1'b1);
        prev_grant = (bus.aux_grant === 1'b1);

        if (m_upd) begin
            if (eng_mode == 2 || (eng_mode == 0 && $urandom_range(0, 7) == 0)) done_at = -1;
            else if (eng_mode == 1) done_at = cyc + 5;
            else if (eng_mode == 3) done_at = cyc + int'($urandom_range(0, 1));
            else done_at = cyc + int'($urandom_range(0, 6));
        end
        done = (cyc == done_at) || (spur_en && ($urandom_range(0, 15) == 0));

        if (aux_cur) begin
            if (m_phase == P_AUX) begin
                if (aux_hold <= 1) aux_cur = 1'b0;
                else aux_hold--;
            end
        end else if (aux_mode == 2 || (aux_mode == 1 && $urandom_range(0, 3) == 0)) begin
            aux_cur  = 1'b1;
            aux_hold = int'($urandom_range(1, 3));
        end

        acc               = v && !rst && (mq.size() < DEPTH);
        nrst              = rst;
        bus.pkt_valid     = v;
        bus.pkt_type      = h.ptype;
        bus.pkt_sourceID  = h.src;
        bus.pkt_hops      = h.hops;
        bus.pkt_clusterID = h.clus;
        bus.pkt_energy    = h.energy;
        bus.pkt_qvalue    = h.qv;
        bus.pkt_knownCH   = h.ch;
        bus.upd_done      = done;
        bus.aux_req       = aux_cur;
        if (rst) model_reset();
        else model_tick(v, h, done, aux_cur);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, rand_hdr(16'hFFFF, 1'b0), 1'b0, a);
    endtask

    task automatic push(input hdr_t h);
        bit a = 1'b0;
        int tries = 0;
        while (!a && tries < 300) begin
            step(1'b1, h, 1'b0, a);
            tries++;
        end
        check("push_acc", 160'(a), 160'(1));
    endtask

    task automatic drain(input int bound);
        bit a;
        int n = 0;
        while ((m_phase != P_IDLE || mq.size() != 0 || aux_cur) && n < bound) begin
            step(1'b0, rand_hdr(16'hFFFF, 1'b0), 1'b0, a);
            n++;
        end
        check("drain_idle", 160'(bus.busy), 160'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        hdr_t h;
        int   c;
        int   u;
        int   b;
        int   n;

        nrst              = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.pkt_type      = 3'b000;
        bus.pkt_sourceID  = '0;
        bus.pkt_hops      = '0;
        bus.pkt_clusterID = '0;
        bus.pkt_energy    = '0;
        bus.pkt_qvalue    = '0;
        bus.pkt_knownCH   = '0;
        bus.upd_done      = 1'b0;
        bus.aux_req       = 1'b0;
        aux_mode = 0;
        eng_mode = 1;
        spur_en  = 1'b0;
        aux_hold = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ready", 160'(bus.pkt_ready), 160'(1));
        check("rst_outs", 160'({bus.upd_en, bus.aux_grant, bus.mem_sel, bus.busy,
                                bus.timeout_err, bus.drop_count, bus.done_count}), 160'(0));

        // Single update: latency, operands, completion
        h = '{ptype: 3'b101, src: 16'd1, hops: 16'd2, clus: 16'd2,
              energy: 16'h8000, qv: 16'h3000, ch: 16'd2};
        c = cyc;
        step(1'b1, h, 1'b0, a);
        check("t1_acc", 160'(a), 160'(1));
        n = 0;
        while (bus.upd_en !== 1'b1 && n < 20) begin
            step(1'b0, h, 1'b0, a);
            n++;
        end
        check("t1_latency", 160'(cyc - c), 160'(3));
        check("t1_fields", 160'({bus.fPacketType, bus.fSourceID, bus.fSourceHops, bus.fClusterID,
                                 bus.fEnergyLeft, bus.fQValue, bus.fKnownCH}), 160'(h));
        drain(100);
        check("t1_done", 160'(bus.done_count), 160'(1));

        // Five back-to-back headers with a fast engine
        eng_mode = 3;
        launched.delete();
        for (int i = 1; i <= 5; i++) push(rand_hdr(16'(i), 1'b0));
        drain(300);
        check("t2_count", 160'(launched.size()), 160'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < launched.size()) check("t2_order", 160'(launched[i]), 160'(i + 1));
        end
        check("t2_done", 160'(bus.done_count), 160'(6));

        // Filtered types and drop counter saturation
        h = rand_hdr(16'd7, 1'b0);
        h.ptype = 3'b000;
        push(h);
        h.ptype = 3'b111;
        push(h);
        idle(2);
        check("t3_drop2", 160'(bus.drop_count), 160'(2));
        check("t3_noupd", 160'(launched.size()), 160'(5));
        for (int i = 0; i < 256; i++) begin
            h.ptype = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            push(h);
        end
        idle(1);
        check("t3_sat", 160'(bus.drop_count), 160'(255));

        // Engine and aux competing: slots must alternate
        aux_mode = 2;
        slot_seq.delete();
        for (int i = 0; i < 3; i++) push(rand_hdr(16'(10 + i), 1'b0));
        idle(80);
        aux_mode = 0;
        drain(200);
        check("t4_slots", 160'(slot_seq.size() >= 6), 160'(1));
        if (slot_seq.size() > 0) check("t4_first", 160'(slot_seq[0]), 160'(1));
        for (int i = 1; i < 6; i++) begin
            if (i < slot_seq.size()) check("t4_alt", 160'(slot_seq[i]), 160'(!slot_seq[i - 1]));
        end

        // Engine never answers: timeout length, sticky error, recovery
        eng_mode = 2;
        push(rand_hdr(16'd20, 1'b0));
        n = 0;
        while (bus.upd_en !== 1'b1 && n < 20) begin
            idle(1);
            n++;
        end
        u = cyc;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            idle(1);
            n++;
        end
        b = cyc;
        check("t5_len", 160'(b - u), 160'(TMO));
        check("t5_err", 160'(bus.timeout_err), 160'(1));
        eng_mode = 1;
        launched.delete();
        push(rand_hdr(16'd21, 1'b0));
        drain(100);
        check("t5_next", 160'(launched.size()), 160'(1));
        check("t5_sticky", 160'(bus.timeout_err), 160'(1));

        // Random traffic with aux contention, spurious done and timeouts
        eng_mode = 0;
        aux_mode = 1;
        spur_en  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_hdr(W'($urandom), 1'b1), 1'b0, a);
        end
        aux_mode = 0;
        spur_en  = 1'b0;
        eng_mode = 3;
        drain(600);

        // Reset while waiting on the engine with two headers queued
        eng_mode = 2;
        for (int i = 0; i < 3; i++) push(rand_hdr(16'(30 + i), 1'b0));
        n = 0;
        while (!(m_phase == P_WAIT && mq.size() == 2) && n < 50) begin
            idle(1);
            n++;
        end
        step(1'b0, rand_hdr(16'd0, 1'b0), 1'b1, a);
        check("t6_busy", 160'(bus.busy), 160'(0));
        check("t6_ready", 160'(bus.pkt_ready), 160'(1));
        check("t6_cnt", 160'({bus.drop_count, bus.done_count, bus.timeout_err}), 160'(0));
        launched.delete();
        idle(5);
        check("t6_noupd", 160'(launched.size()), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
